// File: rtl/pio_pkg.sv
// Shared constants for the multi-width PIO block: register map, edge modes and bus width.
package pio_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_IN      = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_OUT     = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_OUTSET  = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_OUTCLR  = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_IRQMASK = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_EDGECAP = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// Input synchroniser plus per-bit edge pulses; pulses appear SYNC_STAGES cycles after the pin
// changes and are gated off until SYNC_STAGES+1 cycles after reset release. No backpressure.
module pio_sync_edge
    import pio_pkg::*;
#(
    parameter int W           = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = EDGE_RISE
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_sync,
    output logic [W-1:0] o_edge
);

    localparam logic [2:0] ARM_VAL = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][W-1:0] r_chain;
    logic [W-1:0]                  r_prev;
    logic [2:0]                    r_arm_cnt;
    logic                          w_armed;
    logic [W-1:0]                  w_sync;
    logic [W-1:0]                  w_sel;

    if (EDGE_MODE < EDGE_RISE || EDGE_MODE > EDGE_ANY) begin : g_bad_edge_mode
        $error("pio_sync_edge: EDGE_MODE must be 0 (rise), 1 (fall) or 2 (any)");
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_chain   <= '0;
            r_prev    <= '0;
            r_arm_cnt <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_din};
            r_prev  <= w_sync;
            if (!w_armed) begin
                r_arm_cnt <= r_arm_cnt + 3'd1;
            end
        end
    end

    assign w_sync  = r_chain[SYNC_STAGES-1];
    assign w_armed = (r_arm_cnt == ARM_VAL);

    always_comb begin
        w_sel = '0;
        case (EDGE_MODE)
            EDGE_RISE: w_sel = w_sync & ~r_prev;
            EDGE_FALL: w_sel = ~w_sync & r_prev;
            default:   w_sel = w_sync ^ r_prev;
        endcase
    end

    // Suppressing capture while the chain fills hides pins that were already high at reset.
    assign o_edge = w_armed ? w_sel : '0;
    assign o_sync = w_sync;

endmodule

// File: rtl/pio_multi.sv
// Avalon-MM PIO: configurable-width input with edge capture/irq and output with set/clear.
// Writes land on the sampling edge, reads return one cycle later; the slave never stalls.
module pio_multi
    import pio_pkg::*;
#(
    parameter int               IN_W        = 8,
    parameter int               OUT_W       = 8,
    parameter int               EDGE_MODE   = EDGE_RISE,
    parameter int               SYNC_STAGES = 2,
    parameter logic [OUT_W-1:0] OUT_RESET   = '0
) (
    input  logic              clk_50,
    input  logic              reset_reset,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_readdatavalid,
    input  logic [IN_W-1:0]   in_port,
    output logic [OUT_W-1:0]  out_port,
    output logic              irq
);

    if (IN_W < 1 || IN_W > DATA_W || OUT_W < 1 || OUT_W > DATA_W) begin : g_bad_width
        $error("pio_multi: IN_W and OUT_W must be in 1..32");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("pio_multi: SYNC_STAGES must be in 2..4");
    end

    logic [OUT_W-1:0]  r_out;
    logic [IN_W-1:0]   r_mask;
    logic [IN_W-1:0]   r_edgecap;
    logic              r_irq;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;

    logic [IN_W-1:0]   w_sync;
    logic [IN_W-1:0]   w_edge;
    logic [IN_W-1:0]   w_clr;
    logic [OUT_W-1:0]  w_wdat_out;
    logic [IN_W-1:0]   w_wdat_in;
    logic [DATA_W-1:0] w_rd_mux;
    logic              w_unused;

    pio_sync_edge #(
        .W           (IN_W),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_MODE   (EDGE_MODE)
    ) u_sync_edge (
        .i_clk  (clk_50),
        .i_rst  (reset_reset),
        .i_din  (in_port),
        .o_sync (w_sync),
        .o_edge (w_edge)
    );

    assign w_wdat_out = avs_writedata[OUT_W-1:0];
    assign w_wdat_in  = avs_writedata[IN_W-1:0];
    assign w_clr      = (avs_write && avs_address == ADDR_EDGECAP) ? w_wdat_in : '0;
    assign w_unused   = ^avs_writedata;

    always_ff @(posedge clk_50 or posedge reset_reset) begin
        if (reset_reset) begin
            r_out  <= OUT_RESET;
            r_mask <= '0;
        end else if (avs_write) begin
            case (avs_address)
                ADDR_OUT:     r_out  <= w_wdat_out;
                ADDR_OUTSET:  r_out  <= r_out | w_wdat_out;
                ADDR_OUTCLR:  r_out  <= r_out & ~w_wdat_out;
                ADDR_IRQMASK: r_mask <= w_wdat_in;
                default: ;
            endcase
        end
    end

    // A new edge in the same cycle as a W1C keeps the bit set so no event is lost.
    always_ff @(posedge clk_50 or posedge reset_reset) begin
        if (reset_reset) begin
            r_edgecap <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_edgecap <= w_edge | (r_edgecap & ~w_clr);
            r_irq     <= |(r_edgecap & r_mask);
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (avs_address)
            ADDR_IN:      w_rd_mux = DATA_W'(w_sync);
            ADDR_OUT:     w_rd_mux = DATA_W'(r_out);
            ADDR_IRQMASK: w_rd_mux = DATA_W'(r_mask);
            ADDR_EDGECAP: w_rd_mux = DATA_W'(r_edgecap);
            default:      w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_50 or posedge reset_reset) begin
        if (reset_reset) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rdata  <= avs_read ? w_rd_mux : '0;
            r_rvalid <= avs_read;
        end
    end

    assign avs_readdata      = r_rdata;
    assign avs_readdatavalid = r_rvalid;
    assign out_port          = r_out;
    assign irq               = r_irq;

endmodule

// File: tb/tb_pio_multi.sv
// Two DUTs (rising-edge and any-edge capture) share one bus; reads are scored through queues.
module tb_pio_multi;
    import pio_pkg::*;

    typedef struct {
        logic [31:0] dat;
        int          due;
    } exp_t;

    logic        clk_50 = 1'b0;
    logic        reset_reset;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [7:0]  in_port;

    logic [31:0] rdata_r, rdata_a;
    logic        rv_r, rv_a;
    logic [7:0]  out_r, out_a;
    logic        irq_r, irq_a;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t q_r[$];
    exp_t q_a[$];
    exp_t m_r, m_a;

    pio_multi #(
        .IN_W(8), .OUT_W(8), .EDGE_MODE(EDGE_RISE), .SYNC_STAGES(2), .OUT_RESET(8'hA5)
    ) u_rise (
        .clk_50(clk_50), .reset_reset(reset_reset), .avs_address(avs_address),
        .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_readdata(rdata_r), .avs_readdatavalid(rv_r), .in_port(in_port),
        .out_port(out_r), .irq(irq_r)
    );

    pio_multi #(
        .IN_W(8), .OUT_W(8), .EDGE_MODE(EDGE_ANY), .SYNC_STAGES(2), .OUT_RESET(8'hA5)
    ) u_any (
        .clk_50(clk_50), .reset_reset(reset_reset), .avs_address(avs_address),
        .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_readdata(rdata_a), .avs_readdatavalid(rv_a), .in_port(in_port),
        .out_port(out_a), .irq(irq_a)
    );

    always #5 clk_50 = ~clk_50;
    always @(posedge clk_50) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    task automatic chk_out(input logic [7:0] req);
        chk("out_port_rise", 32'(out_r), 32'(req));
        chk("out_port_any", 32'(out_a), 32'(req));
    endtask

    task automatic chk_irq(input logic req_r, input logic req_a);
        chk("irq_rise", 32'(irq_r), 32'(req_r));
        chk("irq_any", 32'(irq_a), 32'(req_a));
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        avs_write = 1'b1; avs_address = a; avs_writedata = d;
        tick();
        avs_write = 1'b0; avs_writedata = '0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e_r, input logic [31:0] e_a);
        q_r.push_back('{dat: e_r, due: cyc + 1});
        q_a.push_back('{dat: e_a, due: cyc + 1});
        avs_read = 1'b1; avs_address = a;
        tick();
        avs_read = 1'b0;
    endtask

    task automatic rw(input logic [2:0] a, input logic [31:0] d, input logic [31:0] e);
        q_r.push_back('{dat: e, due: cyc + 1});
        q_a.push_back('{dat: e, due: cyc + 1});
        avs_read = 1'b1; avs_write = 1'b1; avs_address = a; avs_writedata = d;
        tick();
        avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    endtask

    always @(negedge clk_50) begin
        if (rv_r) begin
            if (q_r.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL rd_rise: got readdatavalid with data %h, required no response", rdata_r);
            end else begin
                m_r = q_r.pop_front();
                chk("rd_rise_data", rdata_r, m_r.dat);
                chk("rd_rise_cycle", cyc, m_r.due);
            end
        end
    end

    always @(negedge clk_50) begin
        if (rv_a) begin
            if (q_a.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL rd_any: got readdatavalid with data %h, required no response", rdata_a);
            end else begin
                m_a = q_a.pop_front();
                chk("rd_any_data", rdata_a, m_a.dat);
                chk("rd_any_cycle", cyc, m_a.due);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run still active at 100us, required completion");
        $fatal(1);
    end

    initial begin
        reset_reset = 1'b1; in_port = 8'hFF;
        avs_read = 1'b0; avs_write = 1'b0; avs_address = '0; avs_writedata = '0;

        // reset values, inputs held high through release must not capture
        repeat (3) tick();
        chk_out(8'hA5);
        chk_irq(1'b0, 1'b0);
        chk("rvalid_rst", 32'(rv_r), 32'd0);
        chk("rdata_rst", rdata_r, 32'd0);
        reset_reset = 1'b0;
        repeat (10) tick();
        rd(ADDR_EDGECAP, 32'h0, 32'h0);
        rd(ADDR_IN, 32'hFF, 32'hFF);
        chk_irq(1'b0, 1'b0);

        // output load / set / clear, write-ignore and read-before-write
        wr(ADDR_OUT, 32'h0F);    chk_out(8'h0F);
        wr(ADDR_OUTSET, 32'hF0); chk_out(8'hFF);
        wr(ADDR_OUTCLR, 32'h81); chk_out(8'h7E);
        rd(ADDR_OUT, 32'h7E, 32'h7E);
        rd(ADDR_OUTSET, 32'h0, 32'h0);
        rd(ADDR_OUTCLR, 32'h0, 32'h0);
        rd(3'd6, 32'h0, 32'h0);
        rd(3'd7, 32'h0, 32'h0);
        wr(ADDR_IN, 32'h12);
        wr(3'd6, 32'hFFFF_FFFF);
        chk_out(8'h7E);
        rd(ADDR_IN, 32'hFF, 32'hFF);
        rw(ADDR_OUT, 32'h55, 32'h7E);
        chk_out(8'h55);
        rd(ADDR_OUT, 32'h55, 32'h55);

        // falling edge only seen by the any-edge instance
        in_port = 8'h00;
        repeat (5) tick();
        rd(ADDR_EDGECAP, 32'h00, 32'hFF);
        wr(ADDR_EDGECAP, 32'hFF);
        rd(ADDR_EDGECAP, 32'h00, 32'h00);

        // rising edge latency, irq one cycle behind EDGECAP
        wr(ADDR_IRQMASK, 32'hFFFF_FF04);
        rd(ADDR_IRQMASK, 32'h04, 32'h04);
        in_port = 8'h04;
        rd(ADDR_EDGECAP, 32'h0, 32'h0);
        rd(ADDR_EDGECAP, 32'h0, 32'h0);
        rd(ADDR_EDGECAP, 32'h0, 32'h0);
        chk_irq(1'b0, 1'b0);
        rd(ADDR_EDGECAP, 32'h04, 32'h04);
        chk_irq(1'b1, 1'b1);

        // edge arriving on the same cycle as W1C wins
        in_port = 8'h00;
        repeat (5) tick();
        chk_irq(1'b1, 1'b1);
        rd(ADDR_EDGECAP, 32'h04, 32'h04);
        in_port = 8'h04;
        tick();
        tick();
        wr(ADDR_EDGECAP, 32'h04);
        chk_irq(1'b1, 1'b1);
        rd(ADDR_EDGECAP, 32'h04, 32'h04);
        chk_irq(1'b1, 1'b1);

        // plain W1C, irq drops one cycle later
        wr(ADDR_EDGECAP, 32'h04);
        chk_irq(1'b1, 1'b1);
        rd(ADDR_EDGECAP, 32'h0, 32'h0);
        chk_irq(1'b0, 1'b0);

        // masked capture, then unmask
        wr(ADDR_IRQMASK, 32'h0);
        in_port = 8'h05;
        repeat (5) tick();
        wr(ADDR_EDGECAP, 32'hFF);
        rd(ADDR_EDGECAP, 32'h0, 32'h0);
        in_port = 8'h04;
        repeat (5) tick();
        rd(ADDR_EDGECAP, 32'h00, 32'h01);
        chk_irq(1'b0, 1'b0);
        wr(ADDR_IRQMASK, 32'h01);
        chk_irq(1'b0, 1'b0);
        rd(ADDR_IRQMASK, 32'h01, 32'h01);
        chk_irq(1'b0, 1'b1);

        // reset in the middle of a read
        wr(ADDR_OUT, 32'hFFFF_FF3C);
        chk_out(8'h3C);
        avs_address = ADDR_OUT; avs_read = 1'b1;
        #2;
        reset_reset = 1'b1;
        #1;
        chk_out(8'hA5);
        chk_irq(1'b0, 1'b0);
        tick();
        avs_read = 1'b0;
        chk("rvalid_in_rst_rise", 32'(rv_r), 32'd0);
        chk("rvalid_in_rst_any", 32'(rv_a), 32'd0);
        tick();
        reset_reset = 1'b0;
        repeat (10) tick();
        rd(ADDR_OUT, 32'hA5, 32'hA5);
        rd(ADDR_IRQMASK, 32'h0, 32'h0);
        rd(ADDR_EDGECAP, 32'h0, 32'h0);
        rd(ADDR_IN, 32'h04, 32'h04);
        chk_irq(1'b0, 1'b0);

        tick();
        tick();
        chk("pending_reads_rise", 32'(q_r.size()), 32'd0);
        chk("pending_reads_any", 32'(q_a.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
